uk101_video_timing: RTL and testbench
=====================================

Name: uk101_video_timing

Overview:
- Parametrised, run-time-configurable video timing and pixel clock-enable generator; successor to the fixed divide-by-6 CE counter.
- Adds a programmable CE divider and programmable horizontal/vertical timing, so one block serves the 64x32 and 48x16 screen modes.
- Timing registers are shadowed and switch only at frame boundaries.
- Character-cell counters (column, row, scanline-in-cell, pixel-in-cell) feed the video RAM/char ROM fetch; sync, blank and DE outputs feed video_cleaner and video_mixer.

Parameters:
- CHAR_W, 8, pixels per character cell horizontally, >=2.
- CHAR_H, 8, scanlines per character cell vertically, >=2.
- CNT_W, 11, width of horizontal and vertical counters and timing inputs.
- DEF_H_ACTIVE, DEF_H_SS, DEF_H_SE, DEF_H_TOTAL, 512/560/608/640, horizontal reset values of the shadow registers.
- DEF_V_ACTIVE, DEF_V_SS, DEF_V_SE, DEF_V_TOTAL, 256/272/276/312, vertical reset values of the shadow registers.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- ce_div  in  4  CE period minus 1; 0 gives CE every cycle, 5 gives 1 in 6. Sampled continuously.
- h_active, h_ss, h_se, h_total  in  CNT_W each  horizontal config: active width, sync start, sync end (exclusive), total.
- v_active, v_ss, v_se, v_total  in  CNT_W each  vertical equivalents.
- ce_pix  out  1  pixel clock enable.
- hcount, vcount  out  CNT_W  current pixel position.
- hsync, vsync  out  1  active-high sync.
- hblank, vblank, de  out  1  blanking flags; de = ~hblank & ~vblank.
- pix_x  out  $clog2(CHAR_W)  pixel within cell.
- char_col  out  8  cell column.
- char_line  out  $clog2(CHAR_H)  scanline within cell.
- char_row  out  8  cell row.
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0).

Behaviour:
- Reset (async):
  - CE divider count, hcount, vcount, pix_x, char_col, char_line, char_row, ce_pix and frame_start go to 0.
  - Shadow registers load the DEF_* values.
  - hsync and vsync go to 0; hblank and vblank go to 0; de goes to 1. This matches position (0,0) under the default config.
- CE divider:
  - The count increments every clk.
  - When count >= ce_div, count returns to 0 and ce_pix is registered high for exactly one clk.
  - If ce_div is lowered below the current count, the next cycle wraps. There is no lock-up.
- Counter advance: occurs only on clk edges where ce_pix = 1. All other outputs hold between CEs.
- Horizontal:
  - hcount increments; at hcount = h_total_r-1 it wraps to 0 and the vertical advance occurs.
- Vertical:
  - vcount increments; at v_total_r-1 it wraps to 0.
  - On this frame wrap, all eight shadow registers load from the inputs, and frame_start pulses in the same edge.
  - Config changes mid-frame have no effect until the wrap.
- Cell counters, horizontal:
  - pix_x counts 0..CHAR_W-1 while hcount < h_active_r.
  - On pix_x wrap, char_col increments.
  - pix_x and char_col reset to 0 on the horizontal wrap and hold during hblank.
- Cell counters, vertical:
  - char_line advances on each horizontal wrap while vcount < v_active_r, wrapping at CHAR_H-1 and then incrementing char_row.
  - Both reset on the frame wrap and hold during vblank.
  - char_col and char_row wrap modulo 256.
- Flag decode:
  - hblank = (hcount >= h_active_r); hsync = (h_ss_r <= hcount < h_se_r).
  - vblank, vsync use the same rules vertically.
  - All flags are registered from next-state counter values, so they are coherent with hcount/vcount in the same cycle. Latency from counter to flag is 0 in visible terms.
- Degenerate config: a loaded total of 0 or 1 is treated as 2. A sync window with se <= ss yields sync never asserted.
- Reset mid-frame: immediate return to the reset state. The first frame after reset always uses the DEF_* timing.

Test Plan:
1. Reset, ce_div=5 -> ce_pix pulses exactly every 6 clk. It is high 1 clk, first pulse 6 clks after release.
2. Config loaded via one frame wrap: ce_div=0, h 4/5/6/8, v 2/3/4/5 -> per line, de=1 for hcount 0..3, hsync=1 for hcount 5. vsync=1 on line 3 only. frame_start every 40 clk.
3. CHAR_W=2, CHAR_H=2, h_active=4, v_active=4 -> char_col sequence 0,0,1,1 then holds 1 in blank. char_row 0,0,1,1 across lines, reset to 0 at the frame wrap.
4. Change h_total 8->10 mid-frame -> the current frame keeps 8-pixel lines. Lines are 10 pixels from the frame after frame_start.
5. ce_div changed from 5 to 1 while the count = 4 -> wraps next clk, then CE every 2 clk. No missed or double pulse beyond that transition.
6. Assert reset at hcount=3, vcount=2 -> all counters 0 asynchronously, de=1, shadow registers reload DEF_* values. Normal operation resumes on release.

Source files
------------

// File: rtl/uk101_video_timing.sv
// uk101_video_timing: programmable pixel CE divider plus shadowed video timing and character-cell counters.
// Timing config is captured only on the frame wrap, so mid-frame writes never tear a frame.
module uk101_video_timing #(
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 8,
    parameter int CNT_W        = 11,
    parameter int DEF_H_ACTIVE = 512,
    parameter int DEF_H_SS     = 560,
    parameter int DEF_H_SE     = 608,
    parameter int DEF_H_TOTAL  = 640,
    parameter int DEF_V_ACTIVE = 256,
    parameter int DEF_V_SS     = 272,
    parameter int DEF_V_SE     = 276,
    parameter int DEF_V_TOTAL  = 312
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic [3:0]                  ce_div,
    input  logic [CNT_W-1:0]            h_active,
    input  logic [CNT_W-1:0]            h_ss,
    input  logic [CNT_W-1:0]            h_se,
    input  logic [CNT_W-1:0]            h_total,
    input  logic [CNT_W-1:0]            v_active,
    input  logic [CNT_W-1:0]            v_ss,
    input  logic [CNT_W-1:0]            v_se,
    input  logic [CNT_W-1:0]            v_total,
    output logic                        ce_pix,
    output logic [CNT_W-1:0]            hcount,
    output logic [CNT_W-1:0]            vcount,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        hblank,
    output logic                        vblank,
    output logic                        de,
    output logic [$clog2(CHAR_W)-1:0]   pix_x,
    output logic [7:0]                  char_col,
    output logic [$clog2(CHAR_H)-1:0]   char_line,
    output logic [7:0]                  char_row,
    output logic                        frame_start
);
    localparam int XW = $clog2(CHAR_W);
    localparam int YW = $clog2(CHAR_H);
    localparam int DEF_HT = DEF_H_TOTAL < 2 ? 2 : DEF_H_TOTAL;
    localparam int DEF_VT = DEF_V_TOTAL < 2 ? 2 : DEF_V_TOTAL;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    logic [3:0]       cnt;
    logic [CNT_W-1:0] ha_r, hs_r, he_r, ht_r, va_r, vs_r, ve_r, vt_r;
    logic [CNT_W-1:0] ha_n, hs_n, he_n, ht_n, va_n, vs_n, ve_n, vt_n;
    logic [CNT_W-1:0] h_nxt, v_nxt;
    logic             h_last, v_last, h_wrap, f_wrap;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            ce_pix <= 1'b0;
        end else begin
            ce_pix <= cnt >= ce_div;
            cnt    <= cnt >= ce_div ? 4'd0 : cnt + 4'd1;
        end
    end

    // Totals are clamped to 2 at load so the wrap compare never underflows.
    always_comb begin
        h_last = hcount >= ht_r - ONE;
        v_last = vcount >= vt_r - ONE;
        h_wrap = ce_pix & h_last;
        f_wrap = h_wrap & v_last;
        h_nxt  = ce_pix ? (h_last ? '0 : hcount + ONE) : hcount;
        v_nxt  = h_wrap ? (v_last ? '0 : vcount + ONE) : vcount;
        ha_n   = f_wrap ? h_active : ha_r;
        hs_n   = f_wrap ? h_ss : hs_r;
        he_n   = f_wrap ? h_se : he_r;
        ht_n   = f_wrap ? (h_total < TWO ? TWO : h_total) : ht_r;
        va_n   = f_wrap ? v_active : va_r;
        vs_n   = f_wrap ? v_ss : vs_r;
        ve_n   = f_wrap ? v_se : ve_r;
        vt_n   = f_wrap ? (v_total < TWO ? TWO : v_total) : vt_r;
    end

    // Flags decode the next-state counters so they line up with hcount/vcount.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hcount      <= '0;
            vcount      <= '0;
            ha_r        <= CNT_W'(DEF_H_ACTIVE);
            hs_r        <= CNT_W'(DEF_H_SS);
            he_r        <= CNT_W'(DEF_H_SE);
            ht_r        <= CNT_W'(DEF_HT);
            va_r        <= CNT_W'(DEF_V_ACTIVE);
            vs_r        <= CNT_W'(DEF_V_SS);
            ve_r        <= CNT_W'(DEF_V_SE);
            vt_r        <= CNT_W'(DEF_VT);
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            hblank      <= 1'b0;
            vblank      <= 1'b0;
            de          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            ha_r        <= ha_n;
            hs_r        <= hs_n;
            he_r        <= he_n;
            ht_r        <= ht_n;
            va_r        <= va_n;
            vs_r        <= vs_n;
            ve_r        <= ve_n;
            vt_r        <= vt_n;
            hsync       <= h_nxt >= hs_n && h_nxt < he_n;
            vsync       <= v_nxt >= vs_n && v_nxt < ve_n;
            hblank      <= h_nxt >= ha_n;
            vblank      <= v_nxt >= va_n;
            de          <= h_nxt < ha_n && v_nxt < va_n;
            frame_start <= f_wrap;
        end
    end

    // Cell counters step only when moving onto a visible position, so they freeze in blanking.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pix_x     <= '0;
            char_col  <= '0;
            char_line <= '0;
            char_row  <= '0;
        end else if (ce_pix) begin
            if (h_last) begin
                pix_x    <= '0;
                char_col <= '0;
            end else if (h_nxt < ha_r) begin
                pix_x    <= pix_x == XW'(CHAR_W - 1) ? '0 : pix_x + XW'(1);
                char_col <= pix_x == XW'(CHAR_W - 1) ? char_col + 8'd1 : char_col;
            end
            if (h_last && v_last) begin
                char_line <= '0;
                char_row  <= '0;
            end else if (h_last && v_nxt < va_r) begin
                char_line <= char_line == YW'(CHAR_H - 1) ? '0 : char_line + YW'(1);
                char_row  <= char_line == YW'(CHAR_H - 1) ? char_row + 8'd1 : char_row;
            end
        end
    end
endmodule

// File: tb/tb_uk101_video_timing.sv
// tb_uk101_video_timing: scenario tasks plus randomized configs against a position-level reference model.
module tb_uk101_video_timing;
    localparam int CW = 2, CH = 2, NW = 11;
    localparam int DHA = 16, DHS = 18, DHE = 20, DHT = 24;
    localparam int DVA = 8, DVS = 9, DVE = 10, DVT = 12;

    logic          clk_sys = 1'b0, reset = 1'b1;
    logic [3:0]    ce_div = 4'd5;
    logic [NW-1:0] h_active, h_ss, h_se, h_total, v_active, v_ss, v_se, v_total;
    logic          ce_pix, hsync, vsync, hblank, vblank, de, frame_start;
    logic [NW-1:0] hcount, vcount;
    logic [0:0]    pix_x, char_line;
    logic [7:0]    char_col, char_row;
    logic [46:0]   dut_vec;

    int checks = 0, errors = 0;
    int m_cnt, m_h, m_v;
    logic m_ce, m_fs;
    int s_ha, s_hs, s_he, s_ht, s_va, s_vs, s_ve, s_vt;

    uk101_video_timing #(
        .CHAR_W(CW), .CHAR_H(CH), .CNT_W(NW),
        .DEF_H_ACTIVE(DHA), .DEF_H_SS(DHS), .DEF_H_SE(DHE), .DEF_H_TOTAL(DHT),
        .DEF_V_ACTIVE(DVA), .DEF_V_SS(DVS), .DEF_V_SE(DVE), .DEF_V_TOTAL(DVT)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ce_div(ce_div),
        .h_active(h_active), .h_ss(h_ss), .h_se(h_se), .h_total(h_total),
        .v_active(v_active), .v_ss(v_ss), .v_se(v_se), .v_total(v_total),
        .ce_pix(ce_pix), .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
        .hblank(hblank), .vblank(vblank), .de(de), .pix_x(pix_x), .char_col(char_col),
        .char_line(char_line), .char_row(char_row), .frame_start(frame_start)
    );

    assign dut_vec = {ce_pix, hcount, vcount, hsync, vsync, hblank, vblank, de,
                      pix_x, char_col, char_line, char_row, frame_start};

    always #5 clk_sys = ~clk_sys;

    // Reference: raster position plus the captured timing; every output is derived arithmetically.
    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            m_cnt <= 0; m_ce <= 1'b0; m_h <= 0; m_v <= 0; m_fs <= 1'b0;
            s_ha <= DHA; s_hs <= DHS; s_he <= DHE; s_ht <= DHT;
            s_va <= DVA; s_vs <= DVS; s_ve <= DVE; s_vt <= DVT;
        end else begin
            m_ce  <= m_cnt >= int'(ce_div);
            m_cnt <= m_cnt >= int'(ce_div) ? 0 : m_cnt + 1;
            m_fs  <= 1'b0;
            if (m_ce) begin
                if (m_h == s_ht - 1) begin
                    m_h <= 0;
                    if (m_v == s_vt - 1) begin
                        m_v <= 0; m_fs <= 1'b1;
                        s_ha <= int'(h_active); s_hs <= int'(h_ss); s_he <= int'(h_se);
                        s_ht <= h_total < 2 ? 2 : int'(h_total);
                        s_va <= int'(v_active); s_vs <= int'(v_ss); s_ve <= int'(v_se);
                        s_vt <= v_total < 2 ? 2 : int'(v_total);
                    end else m_v <= m_v + 1;
                end else m_h <= m_h + 1;
            end
        end
    end

    function automatic logic [46:0] model_vec();
        logic hb, vb, hs, vs;
        int eh, ev;
        hb = m_h >= s_ha;
        vb = m_v >= s_va;
        hs = m_h >= s_hs && m_h < s_he;
        vs = m_v >= s_vs && m_v < s_ve;
        eh = s_ha == 0 ? 0 : (m_h < s_ha ? m_h : s_ha - 1);
        ev = s_va == 0 ? 0 : (m_v < s_va ? m_v : s_va - 1);
        return {m_ce, NW'(m_h), NW'(m_v), hs, vs, hb, vb, ~hb & ~vb,
                1'(eh % CW), 8'(eh / CW), 1'(ev % CH), 8'(ev / CH), m_fs};
    endfunction

    task automatic set_cfg(input int ha, hs, he, ht, va, vs, ve, vt);
        h_active = NW'(ha); h_ss = NW'(hs); h_se = NW'(he); h_total = NW'(ht);
        v_active = NW'(va); v_ss = NW'(vs); v_se = NW'(ve); v_total = NW'(vt);
    endtask

    task automatic test_reset();
        @(negedge clk_sys);
        checks++;
        if (dut_vec !== model_vec() || de !== 1'b1 || hcount !== '0) begin
            errors++; $display("FAIL reset_state got %h exp %h", dut_vec, model_vec());
        end
        reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_sys);
            checks++;
            if (ce_pix !== (i % 6 == 0)) begin
                errors++; $display("FAIL ce_div5 cycle %0d got %b exp %b", i, ce_pix, i % 6 == 0);
            end
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL reset_run got %h exp %h", dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_config();
        int n = 0;
        ce_div = 4'd0;
        set_cfg(4, 5, 6, 8, 2, 3, 4, 5);
        @(negedge clk_sys);
        while (frame_start !== 1'b1 && n < 2000) begin @(negedge clk_sys); n++; end
        checks++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL config_wait got timeout exp frame_start"); end
        for (int k = 0; k < 80; k++) begin
            int h = k % 8, v = (k / 8) % 5;
            checks++;
            if (hcount !== NW'(h) || vcount !== NW'(v) || de !== (h < 4 && v < 2) ||
                hsync !== (h == 5) || vsync !== (v == 3) || frame_start !== (k % 40 == 0)) begin
                errors++;
                $display("FAIL config k=%0d got h%0d v%0d de%b hs%b vs%b fs%b exp h%0d v%0d", k, hcount, vcount, de, hsync, vsync, frame_start, h, v);
            end
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL config_model got %h exp %h", dut_vec, model_vec());
            end
            @(negedge clk_sys);
        end
    endtask

    task automatic test_cells();
        int n = 0;
        set_cfg(4, 10, 10, 6, 4, 10, 10, 6);
        @(negedge clk_sys);
        while (frame_start !== 1'b1 && n < 2000) begin @(negedge clk_sys); n++; end
        checks++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL cells_wait got timeout exp frame_start"); end
        for (int k = 0; k < 40; k++) begin
            int h = (k % 36) % 6, v = (k % 36) / 6;
            int eh = h < 4 ? h : 3, ev = v < 4 ? v : 3;
            checks++;
            if (char_col !== 8'(eh / 2) || pix_x !== 1'(eh % 2) || char_row !== 8'(ev / 2) ||
                char_line !== 1'(ev % 2) || hsync !== 1'b0 || vsync !== 1'b0) begin
                errors++;
                $display("FAIL cells k=%0d got col%0d px%0d row%0d ln%0d exp col%0d px%0d row%0d ln%0d", k, char_col, pix_x, char_row, char_line, eh / 2, eh % 2, ev / 2, ev % 2);
            end
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL cells_model got %h exp %h", dut_vec, model_vec());
            end
            @(negedge clk_sys);
        end
    endtask

    task automatic test_midframe();
        int n = 0, mx = 0;
        set_cfg(4, 5, 6, 8, 2, 3, 4, 5);
        @(negedge clk_sys);
        while (frame_start !== 1'b1 && n < 2000) begin @(negedge clk_sys); n++; end
        checks++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL mid_wait got timeout exp frame_start"); end
        h_total = NW'(10);
        for (int k = 0; k < 90; k++) begin
            if (k == 40) begin
                checks++;
                if (frame_start !== 1'b1 || mx != 7) begin
                    errors++; $display("FAIL mid_old got fs%b maxh%0d exp fs1 maxh7", frame_start, mx);
                end
                mx = 0;
            end
            if (int'(hcount) > mx) mx = int'(hcount);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL mid_model got %h exp %h", dut_vec, model_vec());
            end
            @(negedge clk_sys);
        end
        checks++;
        if (mx != 9) begin errors++; $display("FAIL mid_new got maxh%0d exp maxh9", mx); end
    endtask

    task automatic test_ce_change();
        int n = 0;
        ce_div = 4'd5;
        @(negedge clk_sys);
        while (m_cnt != 4 && n < 40) begin @(negedge clk_sys); n++; end
        checks++;
        if (m_cnt != 4) begin errors++; $display("FAIL ce_wait got timeout exp count4"); end
        ce_div = 4'd1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_sys);
            checks++;
            if (ce_pix !== (k % 2 == 1)) begin
                errors++; $display("FAIL ce_change k=%0d got %b exp %b", k, ce_pix, k % 2 == 1);
            end
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL ce_model got %h exp %h", dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0, mh = 0, mv = 0;
        ce_div = 4'd0;
        @(negedge clk_sys);
        while (!(m_h == 3 && m_v == 2) && n < 500) begin @(negedge clk_sys); n++; end
        checks++;
        if (!(hcount === NW'(3) && vcount === NW'(2))) begin
            errors++; $display("FAIL rstmid_wait got h%0d v%0d exp h3 v2", hcount, vcount);
        end
        set_cfg(4, 5, 6, 8, 2, 3, 4, 5);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (hcount !== '0 || vcount !== '0 || de !== 1'b1 || dut_vec !== model_vec()) begin
            errors++; $display("FAIL rstmid_async got %h exp %h", dut_vec, model_vec());
        end
        @(negedge clk_sys);
        reset = 1'b0;
        n = 0;
        @(negedge clk_sys);
        while (frame_start !== 1'b1 && n < 1000) begin
            if (int'(hcount) > mh) mh = int'(hcount);
            if (int'(vcount) > mv) mv = int'(vcount);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL rstmid_model got %h exp %h", dut_vec, model_vec());
            end
            @(negedge clk_sys); n++;
        end
        checks++;
        if (frame_start !== 1'b1 || mh != DHT - 1 || mv != DVT - 1) begin
            errors++; $display("FAIL rstmid_def got fs%b maxh%0d maxv%0d exp fs1 maxh%0d maxv%0d", frame_start, mh, mv, DHT - 1, DVT - 1);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 30; s++) begin
            set_cfg($urandom_range(0, 14), $urandom_range(0, 14), $urandom_range(0, 14), $urandom_range(0, 12),
                    $urandom_range(0, 14), $urandom_range(0, 14), $urandom_range(0, 14), $urandom_range(0, 12));
            ce_div = 4'($urandom_range(0, 3));
            repeat (100) begin
                @(negedge clk_sys);
                checks++;
                if (dut_vec !== model_vec()) begin
                    errors++; $display("FAIL random seg%0d got %h exp %h", s, dut_vec, model_vec());
                end
            end
        end
    endtask

    initial begin
        set_cfg(DHA, DHS, DHE, DHT, DVA, DVS, DVE, DVT);
        repeat (3) @(negedge clk_sys);
        test_reset();
        test_config();
        test_cells();
        test_midframe();
        test_ce_change();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
